// File: rtl/posicao.sv
// Position tracker for the maze robot. It takes the 3-bit movement action code
// (000 stop, 001 N, 010 O, 011 L, 100 S) and keeps an X/Y cell on a bounded grid.
// Moves that would leave the grid, or that run into a sensed wall, are rejected.
// Accepted steps are counted with saturation, and arrival at the goal cell is sticky.
// Optional feature: define POSICAO_VISITADO_EN to add a visited-cell bitmap with the
// novo / distintas outputs.
module posicao #(
   parameter int GRID_X   = 8,
   parameter int GRID_Y   = 8,
   parameter int COORD_W  = 3,
   parameter int X_INI    = 0,
   parameter int Y_INI    = 0,
   parameter int X_ALVO   = 7,
   parameter int Y_ALVO   = 7,
   parameter int PASSOS_W = 8
) (
   input  logic                c4,
   input  logic                reset,
   input  logic [2:0]          acao,
   input  logic                parede,
   output logic [COORD_W-1:0]  pos_x,
   output logic [COORD_W-1:0]  pos_y,
   output logic [PASSOS_W-1:0] passos,
   output logic                colisao,
   output logic                erro,
   output logic                chegou
`ifdef POSICAO_VISITADO_EN
   ,
   output logic                novo,
   output logic [COORD_W*2:0]  distintas
`endif
);

   localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(GRID_X - 1);
   localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(GRID_Y - 1);
   localparam logic [COORD_W-1:0] X_RST   = COORD_W'(X_INI);
   localparam logic [COORD_W-1:0] Y_RST   = COORD_W'(Y_INI);
   localparam logic [COORD_W-1:0] X_GOAL  = COORD_W'(X_ALVO);
   localparam logic [COORD_W-1:0] Y_GOAL  = COORD_W'(Y_ALVO);
   localparam logic [PASSOS_W-1:0] PASSOS_MAX = '1;

   typedef enum logic {EXPLORA = 1'b0, CHEGOU = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [COORD_W-1:0]    pos_x_q, pos_x_d;
   logic [COORD_W-1:0]    pos_y_q, pos_y_d;
   logic [PASSOS_W-1:0]   passos_q, passos_d;
   logic                  colisao_q, colisao_d;
   logic                  erro_q, erro_d;
   logic                  chegou_q, chegou_d;

   // Candidate target cell and request classification
   logic [COORD_W-1:0]    nx, ny;
   logic                  pedido;
   logic                  bloq;

`ifdef POSICAO_VISITADO_EN
   localparam int N_CEL = GRID_X * GRID_Y;
   localparam int IDX_W = (N_CEL > 1) ? $clog2(N_CEL) : 1;
   localparam logic [N_CEL-1:0] VIS_INI = N_CEL'(1) << (Y_INI * GRID_X + X_INI);

   logic [N_CEL-1:0]      vis_q, vis_d;
   logic [COORD_W*2:0]    dist_q, dist_d;
   logic                  novo_q, novo_d;
   logic [IDX_W-1:0]      idx;
   logic                  aceito;
`endif

   // Next-state, position update, step count and pulse generation
   always_comb begin
      state_d   = state_q;
      pos_x_d   = pos_x_q;
      pos_y_d   = pos_y_q;
      passos_d  = passos_q;
      colisao_d = 1'b0;
      erro_d    = 1'b0;
      nx        = pos_x_q;
      ny        = pos_y_q;
      pedido    = 1'b0;
      bloq      = 1'b0;

      if (state_q == EXPLORA) begin
         case (acao)
            3'b000: begin
            end
            3'b001: begin
               pedido = 1'b1;
               if (pos_y_q == Y_MAX) bloq = 1'b1;
               else                  ny   = pos_y_q + COORD_W'(1);
            end
            3'b010: begin
               pedido = 1'b1;
               if (pos_x_q == '0) bloq = 1'b1;
               else               nx   = pos_x_q - COORD_W'(1);
            end
            3'b011: begin
               pedido = 1'b1;
               if (pos_x_q == X_MAX) bloq = 1'b1;
               else                  nx   = pos_x_q + COORD_W'(1);
            end
            3'b100: begin
               pedido = 1'b1;
               if (pos_y_q == '0) bloq = 1'b1;
               else               ny   = pos_y_q - COORD_W'(1);
            end
            default: erro_d = 1'b1;
         endcase

         if (pedido) begin
            // Edge and wall rejects are treated the same way
            if (bloq || parede) begin
               colisao_d = 1'b1;
            end else begin
               pos_x_d = nx;
               pos_y_d = ny;
               if (passos_q != PASSOS_MAX) passos_d = passos_q + PASSOS_W'(1);
            end
         end

         // Also catches a reset position that already sits on the goal
         if (pos_x_d == X_GOAL && pos_y_d == Y_GOAL) state_d = CHEGOU;
      end

      chegou_d = (state_d == CHEGOU);
   end

   // Control and position registers, cleared asynchronously
   always_ff @(posedge c4 or negedge reset) begin
      if (!reset) begin
         state_q   <= EXPLORA;
         pos_x_q   <= X_RST;
         pos_y_q   <= Y_RST;
         passos_q  <= '0;
         colisao_q <= 1'b0;
         erro_q    <= 1'b0;
         chegou_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pos_x_q   <= pos_x_d;
         pos_y_q   <= pos_y_d;
         passos_q  <= passos_d;
         colisao_q <= colisao_d;
         erro_q    <= erro_d;
         chegou_q  <= chegou_d;
      end
   end

   assign pos_x   = pos_x_q;
   assign pos_y   = pos_y_q;
   assign passos  = passos_q;
   assign colisao = colisao_q;
   assign erro    = erro_q;
   assign chegou  = chegou_q;

`ifdef POSICAO_VISITADO_EN
   // Visited bitmap update on accepted moves only
   always_comb begin
      vis_d  = vis_q;
      dist_d = dist_q;
      novo_d = 1'b0;
      aceito = (state_q == EXPLORA) && pedido && !bloq && !parede;
      idx    = IDX_W'(ny) * IDX_W'(GRID_X) + IDX_W'(nx);
      if (aceito && !vis_q[idx]) begin
         vis_d[idx] = 1'b1;
         dist_d     = dist_q + (COORD_W*2+1)'(1);
         novo_d     = 1'b1;
      end
   end

   // Bitmap registers; reset leaves only the start cell marked
   always_ff @(posedge c4 or negedge reset) begin
      if (!reset) begin
         vis_q  <= VIS_INI;
         dist_q <= (COORD_W*2+1)'(1);
         novo_q <= 1'b0;
      end else begin
         vis_q  <= vis_d;
         dist_q <= dist_d;
         novo_q <= novo_d;
      end
   end

   assign novo      = novo_q;
   assign distintas = dist_q;
`endif

endmodule
